flash_phy_scramble_arb: RTL and testbench

// Shares one flash_phy_scramble instance between the read pipeline (de-scramble) and the

---
 rtl/flash_phy_scramble_arb_if.sv | 69 ++++++
 rtl/flash_phy_scramble_arb.sv | 198 +++++++++++++++++++
 tb/tb_flash_phy_scramble_arb.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_phy_scramble_arb_if.sv
// Signal bundle around flash_phy_scramble_arb: read/program requester sides plus the shared scramble unit.
// scr_op_type is the cipher_ops_e encoding carried as a bit: 1 = de-scramble (read path), 0 = scramble.
interface flash_phy_scramble_arb_if #(
    parameter int AddrW = 9,
    parameter int DataW = 64
);
    // requester -> arbiter
    logic             rd_calc_req;
    logic             prog_calc_req;
    logic             rd_op_req;
    logic             prog_op_req;
    logic [AddrW-1:0] rd_addr;
    logic [AddrW-1:0] prog_addr;
    logic [DataW-1:0] rd_scrambled_data;
    logic [DataW-1:0] prog_plain_data;

    // arbiter -> requester
    logic             rd_calc_ack;
    logic             prog_calc_ack;
    logic             rd_op_ack;
    logic             prog_op_ack;
    logic [DataW-1:0] rd_mask;
    logic [DataW-1:0] prog_mask;
    logic [DataW-1:0] rd_plain_data;
    logic [DataW-1:0] prog_scrambled_data;

    // arbiter -> scramble unit
    logic             scr_calc_req;
    logic             scr_op_req;
    logic             scr_op_type;
    logic [AddrW-1:0] scr_addr;
    logic [DataW-1:0] scr_plain_data;
    logic [DataW-1:0] scr_scrambled_data;

    // scramble unit -> arbiter
    logic             scr_calc_ack;
    logic             scr_op_ack;
    logic [DataW-1:0] scr_mask;
    logic [DataW-1:0] scr_rsp_plain_data;
    logic [DataW-1:0] scr_rsp_scrambled_data;

    // status
    logic             busy;
    logic             err;

    modport slave (
        input  rd_calc_req, prog_calc_req, rd_op_req, prog_op_req,
        input  rd_addr, prog_addr, rd_scrambled_data, prog_plain_data,
        output rd_calc_ack, prog_calc_ack, rd_op_ack, prog_op_ack,
        output rd_mask, prog_mask, rd_plain_data, prog_scrambled_data,
        output scr_calc_req, scr_op_req, scr_op_type, scr_addr,
        output scr_plain_data, scr_scrambled_data,
        input  scr_calc_ack, scr_op_ack, scr_mask,
        input  scr_rsp_plain_data, scr_rsp_scrambled_data,
        output busy, err
    );

    modport master (
        output rd_calc_req, prog_calc_req, rd_op_req, prog_op_req,
        output rd_addr, prog_addr, rd_scrambled_data, prog_plain_data,
        input  rd_calc_ack, prog_calc_ack, rd_op_ack, prog_op_ack,
        input  rd_mask, prog_mask, rd_plain_data, prog_scrambled_data,
        input  scr_calc_req, scr_op_req, scr_op_type, scr_addr,
        input  scr_plain_data, scr_scrambled_data,
        output scr_calc_ack, scr_op_ack, scr_mask,
        output scr_rsp_plain_data, scr_rsp_scrambled_data,
        input  busy, err
    );
endinterface

// File: rtl/flash_phy_scramble_arb.sv
// Shares one flash_phy_scramble between the read (de-scramble) and program (scramble) pipelines.
// The mask (calc) and cipher (op) channels are arbitrated independently with round-robin and a stall watchdog.
module flash_phy_scramble_arb #(
    parameter int unsigned TimeoutW  = 8,
    // Widths mirror BankAddrW / DataWidth of flash_phy_pkg.
    parameter int unsigned BankAddrW = 9,
    parameter int unsigned DataWidth = 64
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    flash_phy_scramble_arb_if.slave bus
);

    typedef enum logic { ScrambleOp = 1'b0, DeScrambleOp = 1'b1 } cipher_ops_e;
    typedef enum logic { StIdle = 1'b0, StBusy = 1'b1 } chan_state_e;
    typedef enum logic { OwnRd = 1'b0, OwnProg = 1'b1 } owner_e;

    localparam int NumCh  = 2;
    localparam int ChCalc = 0;
    localparam int ChOp   = 1;
    localparam logic [TimeoutW-1:0] CntMax = '1;

    // Per-channel views of the request/ack wires, indexed by ChCalc / ChOp.
    logic [NumCh-1:0] rd_req;
    logic [NumCh-1:0] prog_req;
    logic [NumCh-1:0] scr_ack;

    assign rd_req   = {bus.rd_op_req,   bus.rd_calc_req};
    assign prog_req = {bus.prog_op_req, bus.prog_calc_req};
    assign scr_ack  = {bus.scr_op_ack,  bus.scr_calc_ack};

    chan_state_e         state_q [NumCh];
    chan_state_e         state_d [NumCh];
    owner_e              owner_q [NumCh];
    owner_e              owner_d [NumCh];
    owner_e              last_q  [NumCh];
    owner_e              last_d  [NumCh];
    logic [TimeoutW-1:0] cnt_q   [NumCh];
    logic [TimeoutW-1:0] cnt_d   [NumCh];
    logic                err_q;
    logic                err_d;

    logic [NumCh-1:0] busy_ch;
    logic [NumCh-1:0] owner_req;
    logic [NumCh-1:0] rd_ack;
    logic [NumCh-1:0] prog_ack;

    // Owner-relative view of each channel; acks are only ever routed while Busy.
    always_comb begin
        for (int ch = 0; ch < NumCh; ch++) begin
            busy_ch[ch]   = (state_q[ch] == StBusy);
            owner_req[ch] = (owner_q[ch] == OwnRd) ? rd_req[ch] : prog_req[ch];
            rd_ack[ch]    = busy_ch[ch] && scr_ack[ch] && (owner_q[ch] == OwnRd);
            prog_ack[ch]  = busy_ch[ch] && scr_ack[ch] && (owner_q[ch] == OwnProg);
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: every state element, the per-channel arrays included, sits on the async reset so an
    // interrupted transaction can never leave a stale owner, pointer or count behind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int ch = 0; ch < NumCh; ch++) begin
                state_q[ch] <= StIdle;
                owner_q[ch] <= OwnRd;
                last_q[ch]  <= OwnProg;   // "prog served last" makes rd win the first contention
                cnt_q[ch]   <= '0;
            end
            err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the same pre-edge values.
            for (int ch = 0; ch < NumCh; ch++) begin
                state_q[ch] <= state_d[ch];
                owner_q[ch] <= owner_d[ch];
                last_q[ch]  <= last_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            err_q <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns every target and no latch is inferred.
        err_d = err_q;
        for (int ch = 0; ch < NumCh; ch++) begin
            state_d[ch] = state_q[ch];
            owner_d[ch] = owner_q[ch];
            last_d[ch]  = last_q[ch];
            cnt_d[ch]   = cnt_q[ch];

            unique case (state_q[ch])
                StIdle: begin
                    if (rd_req[ch] || prog_req[ch]) begin
                        if (rd_req[ch] && prog_req[ch]) begin
                            owner_d[ch] = (last_q[ch] == OwnRd) ? OwnProg : OwnRd;
                        end else begin
                            owner_d[ch] = rd_req[ch] ? OwnRd : OwnProg;
                        end
                        last_d[ch]  = owner_d[ch];
                        state_d[ch] = StBusy;
                        cnt_d[ch]   = '0;
                    end
                end
                StBusy: begin
                    if (scr_ack[ch]) begin
                        state_d[ch] = StIdle;
                    end else if (!owner_req[ch]) begin
                        // Owner abandoned its request: release the channel and flag it.
                        state_d[ch] = StIdle;
                        err_d       = 1'b1;
                    end else begin
                        // Stall: keep the grant, count towards the watchdog limit.
                        if (cnt_q[ch] != CntMax) begin
                            cnt_d[ch] = cnt_q[ch] + TimeoutW'(1);
                        end
                        if (cnt_d[ch] == CntMax) begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d[ch] = StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    logic                 scr_calc_req;
    logic                 scr_op_req;
    cipher_ops_e          scr_op_type;
    logic [BankAddrW-1:0] scr_addr;
    logic [DataWidth-1:0] scr_plain_data;
    logic [DataWidth-1:0] scr_scrambled_data;
    logic [DataWidth-1:0] rd_mask;
    logic [DataWidth-1:0] prog_mask;
    logic [DataWidth-1:0] rd_plain_data;
    logic [DataWidth-1:0] prog_scrambled_data;

    always_comb begin
        scr_calc_req        = 1'b0;
        scr_op_req          = 1'b0;
        scr_op_type         = ScrambleOp;
        scr_addr            = '0;
        scr_plain_data      = '0;
        scr_scrambled_data  = '0;
        rd_mask             = '0;
        prog_mask           = '0;
        rd_plain_data       = '0;
        prog_scrambled_data = '0;

        if (busy_ch[ChCalc]) begin
            scr_calc_req = owner_req[ChCalc];
            scr_addr     = (owner_q[ChCalc] == OwnRd) ? bus.rd_addr : bus.prog_addr;
        end

        // The data lane that does not belong to the op owner stays zero.
        if (busy_ch[ChOp]) begin
            scr_op_req = owner_req[ChOp];
            if (owner_q[ChOp] == OwnRd) begin
                scr_op_type        = DeScrambleOp;
                scr_scrambled_data = bus.rd_scrambled_data;
            end else begin
                scr_plain_data     = bus.prog_plain_data;
            end
        end

        if (rd_ack[ChCalc])   rd_mask             = bus.scr_mask;
        if (prog_ack[ChCalc]) prog_mask           = bus.scr_mask;
        if (rd_ack[ChOp])     rd_plain_data       = bus.scr_rsp_plain_data;
        if (prog_ack[ChOp])   prog_scrambled_data = bus.scr_rsp_scrambled_data;
    end

    assign bus.scr_calc_req        = scr_calc_req;
    assign bus.scr_op_req          = scr_op_req;
    assign bus.scr_op_type         = scr_op_type;
    assign bus.scr_addr            = scr_addr;
    assign bus.scr_plain_data      = scr_plain_data;
    assign bus.scr_scrambled_data  = scr_scrambled_data;

    assign bus.rd_calc_ack         = rd_ack[ChCalc];
    assign bus.prog_calc_ack       = prog_ack[ChCalc];
    assign bus.rd_op_ack           = rd_ack[ChOp];
    assign bus.prog_op_ack         = prog_ack[ChOp];
    assign bus.rd_mask             = rd_mask;
    assign bus.prog_mask           = prog_mask;
    assign bus.rd_plain_data       = rd_plain_data;
    assign bus.prog_scrambled_data = prog_scrambled_data;

    assign bus.busy                = |busy_ch;
    assign bus.err                 = err_q;

endmodule

// File: tb/tb_flash_phy_scramble_arb.sv
// Self-checking bench for flash_phy_scramble_arb: directed scenarios plus randomized arbitration rounds
// checked against a transaction-level round-robin model.
module tb_flash_phy_scramble_arb;

    localparam int   AddrW    = 9;
    localparam int   DataW    = 64;
    localparam int   TimeoutW = 4;
    localparam logic OP_SCR   = 1'b0;
    localparam logic OP_DESCR = 1'b1;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    flash_phy_scramble_arb_if #(.AddrW(AddrW), .DataW(DataW)) bus ();

    flash_phy_scramble_arb #(.TimeoutW(TimeoutW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    // Model: per channel (0 = calc, 1 = op), who was served last (1 = prog).
    bit last_prog [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        bus.rd_calc_req            = 1'b0;
        bus.prog_calc_req          = 1'b0;
        bus.rd_op_req              = 1'b0;
        bus.prog_op_req            = 1'b0;
        bus.rd_addr                = '0;
        bus.prog_addr              = '0;
        bus.rd_scrambled_data      = '0;
        bus.prog_plain_data        = '0;
        bus.scr_calc_ack           = 1'b0;
        bus.scr_op_ack             = 1'b0;
        bus.scr_mask               = '0;
        bus.scr_rsp_plain_data     = '0;
        bus.scr_rsp_scrambled_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni       = 1'b1;
        last_prog[0] = 1'b1;
        last_prog[1] = 1'b1;
    endtask

    task automatic drive_req(input int ch, input bit who_prog, input bit val,
                             input logic [AddrW-1:0] a, input logic [DataW-1:0] d);
        if (ch == 0) begin
            if (who_prog) begin bus.prog_calc_req = val; bus.prog_addr = a; end
            else          begin bus.rd_calc_req   = val; bus.rd_addr   = a; end
        end else begin
            if (who_prog) begin bus.prog_op_req = val; bus.prog_plain_data   = d; end
            else          begin bus.rd_op_req   = val; bus.rd_scrambled_data = d; end
        end
    endtask

    task automatic set_ack(input int ch, input bit val, input logic [DataW-1:0] rsp);
        if (ch == 0) begin
            bus.scr_calc_ack = val;
            bus.scr_mask     = rsp;
        end else begin
            bus.scr_op_ack             = val;
            bus.scr_rsp_plain_data     = rsp;
            bus.scr_rsp_scrambled_data = ~rsp;
        end
    endtask

    task automatic check_view(input int ch, input bit own,
                              input logic [AddrW-1:0] a, input logic [DataW-1:0] d);
        if (ch == 0) begin
            check("calc_scr_req", bus.scr_calc_req, 1'b1);
            check("calc_scr_addr", bus.scr_addr, a);
        end else begin
            check("op_scr_req", bus.scr_op_req, 1'b1);
            check("op_type", bus.scr_op_type, own ? OP_SCR : OP_DESCR);
            check("op_scr_scrambled", bus.scr_scrambled_data, own ? 64'd0 : d);
            check("op_scr_plain", bus.scr_plain_data, own ? d : 64'd0);
        end
    endtask

    task automatic check_acks(input int ch, input bit own, input bit acked, input logic [DataW-1:0] rsp);
        bit r;
        bit p;
        r = acked && !own;
        p = acked && own;
        if (ch == 0) begin
            check("rd_calc_ack", bus.rd_calc_ack, r);
            check("prog_calc_ack", bus.prog_calc_ack, p);
            check("rd_mask", bus.rd_mask, r ? rsp : 64'd0);
            check("prog_mask", bus.prog_mask, p ? rsp : 64'd0);
        end else begin
            check("rd_op_ack", bus.rd_op_ack, r);
            check("prog_op_ack", bus.prog_op_ack, p);
            check("rd_plain", bus.rd_plain_data, r ? rsp : 64'd0);
            check("prog_scrambled", bus.prog_scrambled_data, p ? ~rsp : 64'd0);
        end
    endtask

    // One arbitration round on a channel starting from Idle. The model predicts the
    // grant order: a lone requester is served; with two, the one not served last goes first.
    task automatic run_round(input int ch, input bit want_rd, input bit want_prog);
        bit               order [$];
        bit               first;
        bit               own;
        int               dly;
        logic [AddrW-1:0] addr [2];
        logic [DataW-1:0] din  [2];
        logic [DataW-1:0] rsp;

        first = (want_rd && want_prog) ? !last_prog[ch] : want_prog;
        order.push_back(first);
        if (want_rd && want_prog) order.push_back(!first);

        for (int r = 0; r < 2; r++) begin
            addr[r] = AddrW'($urandom);
            din[r]  = {$urandom, $urandom};
        end
        drive_req(ch, 1'b0, want_rd, addr[0], din[0]);
        drive_req(ch, 1'b1, want_prog, addr[1], din[1]);

        foreach (order[k]) begin
            own = order[k];
            next_cycle();
            dly = int'($urandom_range(0, 3));
            for (int i = 0; i <= dly; i++) begin
                if (i == dly) begin
                    rsp = {$urandom, $urandom};
                    set_ack(ch, 1'b1, rsp);
                end
                sample();
                check_view(ch, own, addr[own], din[own]);
                check_acks(ch, own, i == dly, rsp);
                if (i < dly) next_cycle();
            end
            next_cycle();
            drive_req(ch, own, 1'b0, addr[own], din[own]);
            set_ack(ch, 1'b0, '0);
            sample();
            check(ch == 0 ? "idle_calc_req" : "idle_op_req",
                  ch == 0 ? bus.scr_calc_req : bus.scr_op_req, 1'b0);
            check("idle_busy", bus.busy, 1'b0);
            check_acks(ch, own, 1'b0, '0);
            last_prog[ch] = own;
        end
    endtask

    logic [DataW-1:0] d0;
    logic [DataW-1:0] d1;
    logic [DataW-1:0] r0;
    logic [DataW-1:0] r1;
    logic [AddrW-1:0] a0;

    initial begin
        idle_inputs();

        // ---- reset state ----
        sample();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_scr_calc_req", bus.scr_calc_req, 1'b0);
        check("rst_scr_op_req", bus.scr_op_req, 1'b0);
        check("rst_op_type", bus.scr_op_type, OP_SCR);
        check("rst_scr_addr", bus.scr_addr, '0);

        // ---- single rd op, ack in cycle 3 ----
        do_reset();
        d0 = {$urandom, $urandom};
        drive_req(1, 1'b0, 1'b1, '0, d0);
        sample();
        check("t1_c0_scr_req", bus.scr_op_req, 1'b0);
        next_cycle();
        sample();
        check("t1_c1_busy", bus.busy, 1'b1);
        check_view(1, 1'b0, '0, d0);
        next_cycle();
        sample();
        check_acks(1, 1'b0, 1'b0, '0);
        next_cycle();
        r0 = {$urandom, $urandom};
        set_ack(1, 1'b1, r0);
        sample();
        check_acks(1, 1'b0, 1'b1, r0);
        next_cycle();
        drive_req(1, 1'b0, 1'b0, '0, d0);
        set_ack(1, 1'b0, '0);
        sample();
        check("t1_c4_busy", bus.busy, 1'b0);
        check("t1_c4_scr_req", bus.scr_op_req, 1'b0);

        // ---- op contention: rd first after reset, then prog, then rd again ----
        do_reset();
        run_round(1, 1'b1, 1'b1);
        run_round(1, 1'b1, 1'b1);

        // ---- rd calc concurrent with prog op ----
        do_reset();
        a0 = AddrW'($urandom);
        d1 = {$urandom, $urandom};
        drive_req(0, 1'b0, 1'b1, a0, '0);
        drive_req(1, 1'b1, 1'b1, '0, d1);
        next_cycle();
        r0 = {$urandom, $urandom};
        set_ack(0, 1'b1, r0);
        sample();
        check_view(0, 1'b0, a0, '0);
        check_view(1, 1'b1, '0, d1);
        check_acks(0, 1'b0, 1'b1, r0);
        check_acks(1, 1'b1, 1'b0, '0);
        next_cycle();
        drive_req(0, 1'b0, 1'b0, a0, '0);
        set_ack(0, 1'b0, '0);
        r1 = {$urandom, $urandom};
        set_ack(1, 1'b1, r1);
        sample();
        check_acks(0, 1'b0, 1'b0, '0);
        check_acks(1, 1'b1, 1'b1, r1);
        next_cycle();
        drive_req(1, 1'b1, 1'b0, '0, d1);
        set_ack(1, 1'b0, '0);
        sample();
        check("conc_busy_end", bus.busy, 1'b0);

        // ---- watchdog: no ack for a long time ----
        do_reset();
        a0 = AddrW'($urandom);
        drive_req(0, 1'b1, 1'b1, a0, '0);
        next_cycle();
        for (int i = 1; i <= 18; i++) begin
            sample();
            check("wd_err", bus.err, i >= 16);
            check("wd_busy", bus.busy, 1'b1);
            next_cycle();
        end
        r0 = {$urandom, $urandom};
        set_ack(0, 1'b1, r0);
        sample();
        check_acks(0, 1'b1, 1'b1, r0);
        next_cycle();
        drive_req(0, 1'b1, 1'b0, a0, '0);
        set_ack(0, 1'b0, '0);
        sample();
        check("wd_busy_cleared", bus.busy, 1'b0);
        check("wd_err_sticky", bus.err, 1'b1);

        // ---- owner drops request mid-Busy ----
        do_reset();
        d1 = {$urandom, $urandom};
        drive_req(1, 1'b1, 1'b1, '0, d1);
        next_cycle();
        sample();
        check("drop_scr_req", bus.scr_op_req, 1'b1);
        check("drop_err_before", bus.err, 1'b0);
        next_cycle();
        drive_req(1, 1'b1, 1'b0, '0, d1);
        sample();
        check("drop_scr_req_low", bus.scr_op_req, 1'b0);
        check("drop_still_busy", bus.busy, 1'b1);
        check_acks(1, 1'b1, 1'b0, '0);
        next_cycle();
        sample();
        check("drop_idle", bus.busy, 1'b0);
        check("drop_err", bus.err, 1'b1);
        check_acks(1, 1'b1, 1'b0, '0);

        // ---- async reset with both channels Busy ----
        do_reset();
        d0 = {$urandom, $urandom};
        a0 = AddrW'($urandom);
        drive_req(1, 1'b0, 1'b1, '0, d0);
        drive_req(0, 1'b1, 1'b1, a0, '0);
        next_cycle();
        sample();
        check("ar_both_calc", bus.scr_calc_req, 1'b1);
        check("ar_both_op", bus.scr_op_req, 1'b1);
        #1;
        rst_ni = 1'b0;
        set_ack(1, 1'b1, {$urandom, $urandom});
        #1;
        check("ar_busy", bus.busy, 1'b0);
        check("ar_scr_calc_req", bus.scr_calc_req, 1'b0);
        check("ar_scr_op_req", bus.scr_op_req, 1'b0);
        check("ar_rd_op_ack", bus.rd_op_ack, 1'b0);
        check("ar_rd_plain", bus.rd_plain_data, '0);
        check("ar_op_type", bus.scr_op_type, OP_SCR);
        idle_inputs();
        next_cycle();
        rst_ni       = 1'b1;
        last_prog[0] = 1'b1;
        last_prog[1] = 1'b1;
        a0 = AddrW'($urandom);
        drive_req(0, 1'b0, 1'b1, a0, '0);
        sample();
        check("ar_fresh_n", bus.scr_calc_req, 1'b0);
        next_cycle();
        r0 = {$urandom, $urandom};
        set_ack(0, 1'b1, r0);
        sample();
        check_view(0, 1'b0, a0, '0);
        check_acks(0, 1'b0, 1'b1, r0);
        next_cycle();
        drive_req(0, 1'b0, 1'b0, a0, '0);
        set_ack(0, 1'b0, '0);
        sample();
        check("ar_fresh_done", bus.busy, 1'b0);

        // ---- randomized arbitration rounds on both channels ----
        do_reset();
        for (int n = 0; n < 24; n++) begin
            int ch;
            int pat;
            ch  = int'($urandom_range(0, 1));
            pat = int'($urandom_range(1, 3));
            run_round(ch, pat[0], pat[1]);
        end
        check("rand_err_clear", bus.err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
